// File: rtl/vr_rr_arbiter_if.sv
// valid_ready: single-direction valid/ready handshake bus.
//   valid : producer has a beat on data this cycle
//   ready : consumer can take a beat this cycle
//   data  : beat payload, DATA_WIDTH bits
// A beat transfers on a rising clock edge where valid && ready.
interface valid_ready #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport Master (output valid, output data, input ready);
  modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/vr_rr_arbiter.sv
// vr_rr_arbiter: round-robin arbiter sharing one valid/ready sink between
// NUM_REQ valid/ready sources. One requester is granted at a time for at most
// BURST_LEN beats. Its beats pass through a single registered output stage.
//
// Ports:
//   clk         clock, all logic on posedge
//   reset       synchronous, active-high
//   in_valid    per-requester valid
//   in_ready    per-requester ready (at most one bit high, only for the grantee)
//   in_data     requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   vrBus       downstream sink (valid/data driven from registers, ready in)
//   grant_valid high while a requester holds the grant
//   grant_id    index of the current or most recent grantee
module vr_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int IDW        = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  valid_ready.Master                    vrBus,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state;
  logic [IDW-1:0]        ptr;
  logic [CW-1:0]         beat_cnt;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] out_data;

  logic                  cur_valid;
  logic                  slot_free;
  logic                  accept;
  logic                  last_beat;
  logic                  release_grant;
  logic [IDW-1:0]        next_ptr;

  logic                  found;
  logic [IDW-1:0]        winner;
  int unsigned           scan_idx;

  // Handshake with the current grantee. The output slot can take a new beat
  // when it is empty or is being drained this same cycle.
  always_comb begin
    cur_valid     = in_valid[grant_id];
    slot_free     = !out_full || vrBus.ready;
    accept        = (state == GRANT) && cur_valid && slot_free;
    last_beat     = accept && (beat_cnt == LAST_BEAT);
    release_grant = (state == GRANT) && (!cur_valid || last_beat);
  end

  // Explicit wrap keeps ptr off unused codes when NUM_REQ is not a power of two.
  always_comb begin
    if (grant_id == IDW'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id + 1'b1;
    end
  end

  // Search starts at ptr and wraps modulo NUM_REQ; the first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = 32'(ptr) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!found && in_valid[scan_idx]) begin
        found  = 1'b1;
        winner = IDW'(scan_idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (state == GRANT) begin
      in_ready[grant_id] = slot_free;
    end
  end

  assign grant_valid = (state == GRANT);
  assign vrBus.valid = out_full;
  assign vrBus.data  = out_data;

  // Grant control.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          // The releasing requester becomes lowest priority next time.
          if (release_grant) begin
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage. A load in the same cycle as a drain keeps out_full set, so a
  // burst streams at one beat per cycle; a final beat left here after release
  // drains independently of the grant logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_full <= 1'b0;
      out_data <= '0;
    end else if (accept) begin
      out_full <= 1'b1;
      out_data <= in_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    end else if (vrBus.ready) begin
      out_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
module tb_vr_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic            grant_valid;
  logic [1:0]      grant_id;

  valid_ready #(.DATA_WIDTH(DW)) vr ();

  vr_rr_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .vrBus(vr),
    .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Source-side stimulus: each requester offers the head of its queue while gated on.
  logic [7:0]   src_q[N][$];
  logic [N-1:0] gate = '1;

  // Scoreboard and grant log.
  logic [7:0] exp_q[$];
  int         glog[$];
  bit         prev_gv = 1'b0;
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Reference model: owner is -1 when nobody holds the grant.
  int         m_owner = -1;
  int         m_beats = 0;
  int         m_ptr = 0;
  int         m_last = 0;
  bit         m_full = 1'b0;
  logic [7:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p || (m_owner >= 0) || (exp_q.size() > 0);
  endfunction

  // One clock cycle: drive inputs, check combinational/registered outputs
  // against the model, then advance the model across the coming edge.
  task automatic step(input bit rdy, input bit rst);
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic [N-1:0]    er;
    bit              acc;
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      v[i] = gate[i] && (src_q[i].size() > 0);
      d[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'($urandom);
    end
    in_valid = v;
    in_data  = d;
    vr.ready = rdy;
    reset    = rst;
    #1;
    if (chk_en) begin
      er = '0;
      if (m_owner >= 0 && (!m_full || rdy)) er[m_owner] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      chk("grant_id", 32'(grant_id), m_last);
      chk("out_valid", 32'(vr.valid), 32'(m_full));
      chk("out_data", 32'(vr.data), 32'(m_data));
    end
    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_last = 0;
      m_full = 1'b0; m_data = '0;
      exp_q.delete();
      chk_en = 1'b1;
    end else begin
      acc = (m_owner >= 0) && v[m_owner] && (!m_full || rdy);
      if (acc) begin
        m_data = src_q[m_owner].pop_front();
        m_full = 1'b1;
        exp_q.push_back(m_data);
      end else if (rdy) begin
        m_full = 1'b0;
      end
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && v[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_last  = m_owner;
            m_beats = 0;
          end
        end
      end else if (acc) begin
        m_beats++;
        if (m_beats == BL) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (!v[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    glog.delete();
  endtask

  task automatic run_quiet(input string nm);
    int cyc = 0;
    gate = '1;
    while (pending() && cyc < 300) begin
      step(1'b1, 1'b0);
      cyc++;
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk({nm, "_drain_timeout"}, 32'(cyc >= 300), 32'd0);
    chk({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_glog(input string nm, input int e[$]);
    chk({nm, "_grants"}, 32'(glog.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < glog.size(); i++) chk({nm, "_grant_order"}, 32'(glog[i]), 32'(e[i]));
    glog.delete();
  endtask

  // Monitor: pops the scoreboard on every sink handshake, logs grant starts.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (vr.valid === 1'b1 && vr.ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sink_extra_beat: got %0h expected none at %0t", vr.data, $time);
          end else begin
            chk("sink_beat", 32'(vr.data), 32'(exp_q.pop_front()));
          end
        end
        if (grant_valid === 1'b1 && !prev_gv) glog.push_back(int'(grant_id));
        prev_gv = (grant_valid === 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e[$];
    vr.ready = 1'b0;
    do_reset();
    do_reset();

    // Single requester: two bursts of 4 with one bubble between.
    for (int j = 0; j < 8; j++) src_q[2].push_back(8'(8'h10 + j));
    run_quiet("single");
    e = '{2, 2};
    check_glog("single", e);

    // All requesting from reset.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) src_q[i].push_back(8'(i * 16 + j));
    run_quiet("all");
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_glog("all", e);

    // Early release of req 1 moves priority past it to 3.
    do_reset();
    for (int j = 0; j < 2; j++) src_q[1].push_back(8'(8'h50 + j));
    for (int j = 0; j < 4; j++) src_q[3].push_back(8'(8'h70 + j));
    run_quiet("early");
    e = '{1, 3};
    check_glog("early", e);

    // Wrap: leave ptr at 3, then 0 and 3 compete.
    do_reset();
    src_q[2].push_back(8'h22);
    run_quiet("wrap_setup");
    for (int j = 0; j < 2; j++) begin
      src_q[0].push_back(8'(8'h80 + j));
      src_q[3].push_back(8'(8'hB0 + j));
    end
    run_quiet("wrap");
    e = '{2, 3, 0};
    check_glog("wrap", e);

    // Backpressure mid-burst.
    do_reset();
    for (int j = 0; j < 4; j++) src_q[0].push_back(8'(8'hC0 + j));
    repeat (3) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    run_quiet("bp");
    e = '{0};
    check_glog("bp", e);

    // Reset with a beat buffered.
    do_reset();
    for (int j = 0; j < 8; j++) src_q[1].push_back(8'(8'hD0 + j));
    repeat (3) step(1'b1, 1'b0);
    for (int j = 0; j < 2; j++) src_q[0].push_back(8'(8'hE0 + j));
    do_reset();
    run_quiet("rst_mid");
    e = '{0, 1, 1};
    check_glog("rst_mid", e);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) gate[i] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int r = int'($urandom_range(0, N - 1));
        if (src_q[r].size() < 6) src_q[r].push_back(8'($urandom));
      end
      if ($urandom_range(0, 199) == 0) step(1'b0, 1'b1);
      else step($urandom_range(0, 3) != 0, 1'b0);
    end
    run_quiet("random");
    glog.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
